// File: rtl/ber_pkg.sv
// Shared definitions for the BER measurement path: default counter widths used by the
// measurement sequencer and the 7-segment display block, and the sequencer state encoding.
package ber_pkg;

    localparam int BER_BW_RCNT = 58;
    localparam int BER_BW_ECNT = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACQ  = 2'd1;
    localparam state_t ST_MEAS = 2'd2;
    localparam state_t ST_SNAP = 2'd3;

    // MEAS and SNAP are the states in which the PRBS pattern is considered locked
    function automatic logic is_locked_state(input state_t s);
        return (s == ST_MEAS) || (s == ST_SNAP);
    endfunction

endpackage

// File: rtl/ber_lock_det.sv
// Run-length lock detector: counts consecutive clean valid bits while acquiring and
// consecutive errored valid bits while locked; flags the bit that reaches each threshold.
module ber_lock_det #(
    parameter int LOCK_THR   = 16,
    parameter int UNLOCK_THR = 8
) (
    input  logic CLK,
    input  logic RSTX,
    input  logic acq_en,
    input  logic meas_en,
    input  logic bit_valid,
    input  logic bit_err,
    output logic lock_hit,
    output logic unlock_hit
);

    localparam int LW = (LOCK_THR > 1) ? $clog2(LOCK_THR) : 1;
    localparam int UW = (UNLOCK_THR > 1) ? $clog2(UNLOCK_THR) : 1;
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_THR - 1);
    localparam logic [UW-1:0] UNLOCK_MAX = UW'(UNLOCK_THR - 1);

    logic [LW-1:0] lock_run;
    logic [UW-1:0] unlock_run;

    // Runs saturate one below threshold, so a hit that the sequencer suppresses
    // (e.g. by a same-cycle CLEAR) is raised again by the next qualifying bit.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            lock_run   <= '0;
            unlock_run <= '0;
        end else begin
            if (!acq_en) begin
                lock_run <= '0;
            end else if (bit_valid) begin
                if (bit_err)
                    lock_run <= '0;
                else if (lock_run != LOCK_MAX)
                    lock_run <= lock_run + 1'b1;
            end

            if (!meas_en) begin
                unlock_run <= '0;
            end else if (bit_valid) begin
                if (!bit_err)
                    unlock_run <= '0;
                else if (unlock_run != UNLOCK_MAX)
                    unlock_run <= unlock_run + 1'b1;
            end
        end
    end

    assign lock_hit   = acq_en  && bit_valid && !bit_err && (lock_run == LOCK_MAX);
    assign unlock_hit = meas_en && bit_valid &&  bit_err && (unlock_run == UNLOCK_MAX);

endmodule

// File: rtl/ber_meas_ctrl.sv
// BER measurement sequencer: PRBS lock, bit/error accumulation, windowed or requested
// snapshots with a START pulse to the display. Define BER_MEAS_SAT_EN for saturating counts.
module ber_meas_ctrl
    import ber_pkg::*;
#(
    parameter int BW_RCNT    = BER_BW_RCNT,
    parameter int BW_ECNT    = BER_BW_ECNT,
    parameter int BW_WIN     = 32,
    parameter int LOCK_THR   = 16,
    parameter int UNLOCK_THR = 8
) (
    input  logic               CLK,
    input  logic               RSTX,
    input  logic               ENABLE,
    input  logic               CLEAR,
    input  logic [BW_WIN-1:0]  WIN_LEN,
    input  logic               SNAP_REQ,
    input  logic               BIT_VALID,
    input  logic               BIT_ERR,
    output logic               LOCKED,
    output logic               MEAS_START,
    output logic [BW_RCNT-1:0] RECV_CNT,
    output logic [BW_ECNT-1:0] ERR_CNT
);

    state_t              state, next_state;
    logic [BW_RCNT-1:0]  racc, racc_d;
    logic [BW_ECNT-1:0]  eacc, eacc_d;
    logic [BW_WIN-1:0]   win_cnt, win_d;
    logic                lock_hit, unlock_hit;
    logic                clr, count_en, racc_inc, eacc_inc;
    logic                win_end, snap_trig;
    logic                locked_d, start_d;

    ber_lock_det #(
        .LOCK_THR   (LOCK_THR),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_lock_det (
        .CLK        (CLK),
        .RSTX       (RSTX),
        .acq_en     (state == ST_ACQ),
        .meas_en    (is_locked_state(state)),
        .bit_valid  (BIT_VALID),
        .bit_err    (BIT_ERR),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );

    // ENABLE=0 outranks CLEAR, so a clear while disabled leaves everything held
    assign clr       = ENABLE && CLEAR;
    assign count_en  = ENABLE && !CLEAR && is_locked_state(state) && BIT_VALID;
    assign win_end   = (state == ST_MEAS) && BIT_VALID && (WIN_LEN != '0)
                       && (win_cnt >= WIN_LEN - 1'b1);
    assign snap_trig = (state == ST_MEAS) && (win_end || SNAP_REQ);

`ifdef BER_MEAS_SAT_EN
    // Error count freezes with the received count so the displayed ratio stays meaningful
    logic racc_full, eacc_full;
    assign racc_full = &racc;
    assign eacc_full = &eacc;
    assign racc_inc  = count_en && !racc_full;
    assign eacc_inc  = count_en && BIT_ERR && !racc_full && !eacc_full;
`else
    assign racc_inc  = count_en;
    assign eacc_inc  = count_en && BIT_ERR;
`endif

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no latch is inferred
        next_state = state;
        if (!ENABLE) begin
            next_state = ST_IDLE;
        end else if (CLEAR) begin
            next_state = (state == ST_SNAP) ? ST_MEAS : state;
        end else begin
            case (state)
                ST_IDLE: next_state = ST_ACQ;
                ST_ACQ:  if (lock_hit) next_state = ST_MEAS;
                ST_MEAS: begin
                    if (unlock_hit)     next_state = ST_ACQ;
                    else if (snap_trig) next_state = ST_SNAP;
                end
                ST_SNAP: next_state = unlock_hit ? ST_ACQ : ST_MEAS;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from next_state and registered, so they line up with the state
    always_comb begin
        locked_d = is_locked_state(next_state);
        start_d  = (next_state == ST_SNAP);
    end

    always_comb begin
        racc_d = racc;
        eacc_d = eacc;
        win_d  = win_cnt;
        if (clr) begin
            racc_d = '0;
            eacc_d = '0;
            win_d  = '0;
        end else if (ENABLE) begin
            if (racc_inc) racc_d = racc + 1'b1;
            if (eacc_inc) eacc_d = eacc + 1'b1;
            // Window restarts at every snapshot and is held at 0 until lock
            if (next_state == ST_SNAP || !is_locked_state(state))
                win_d = '0;
            else if (BIT_VALID)
                win_d = win_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            racc       <= '0;
            eacc       <= '0;
            win_cnt    <= '0;
            LOCKED     <= 1'b0;
            MEAS_START <= 1'b0;
            RECV_CNT   <= '0;
            ERR_CNT    <= '0;
        end else begin
            racc       <= racc_d;
            eacc       <= eacc_d;
            win_cnt    <= win_d;
            LOCKED     <= locked_d;
            MEAS_START <= start_d;
            if (clr) begin
                RECV_CNT <= '0;
                ERR_CNT  <= '0;
            end else if (next_state == ST_SNAP) begin
                // Snapshot includes the bit that closed the window
                RECV_CNT <= racc_d;
                ERR_CNT  <= eacc_d;
            end
        end
    end

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Directed bench for ber_meas_ctrl: lock, windows, unlock, clear, saturation/wrap, reset.
// A second instance with a 4-bit received counter covers the BER_MEAS_SAT_EN behaviour.
module tb_ber_meas_ctrl;

    logic        CLK;
    logic        RSTX;
    logic        ENABLE;
    logic        CLEAR;
    logic [31:0] WIN_LEN;
    logic        SNAP_REQ;
    logic        BIT_VALID;
    logic        BIT_ERR;

    logic        locked, meas_start;
    logic [57:0] recv_cnt;
    logic [63:0] err_cnt;

    logic        s_locked, s_meas_start;
    logic [3:0]  s_recv_cnt;
    logic [63:0] s_err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    ber_meas_ctrl dut (
        .CLK        (CLK),
        .RSTX       (RSTX),
        .ENABLE     (ENABLE),
        .CLEAR      (CLEAR),
        .WIN_LEN    (WIN_LEN),
        .SNAP_REQ   (SNAP_REQ),
        .BIT_VALID  (BIT_VALID),
        .BIT_ERR    (BIT_ERR),
        .LOCKED     (locked),
        .MEAS_START (meas_start),
        .RECV_CNT   (recv_cnt),
        .ERR_CNT    (err_cnt)
    );

    ber_meas_ctrl #(.BW_RCNT(4)) dut_small (
        .CLK        (CLK),
        .RSTX       (RSTX),
        .ENABLE     (ENABLE),
        .CLEAR      (CLEAR),
        .WIN_LEN    (WIN_LEN),
        .SNAP_REQ   (SNAP_REQ),
        .BIT_VALID  (BIT_VALID),
        .BIT_ERR    (BIT_ERR),
        .LOCKED     (s_locked),
        .MEAS_START (s_meas_start),
        .RECV_CNT   (s_recv_cnt),
        .ERR_CNT    (s_err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic v, input logic e);
        BIT_VALID = v;
        BIT_ERR   = e;
        tick();
        BIT_VALID = 1'b0;
        BIT_ERR   = 1'b0;
    endtask

    initial begin
        logic [3:0]  exp_small_recv;
        logic [63:0] exp_small_err;
`ifdef BER_MEAS_SAT_EN
        exp_small_recv = 4'd15;
        exp_small_err  = 64'd1;
`else
        exp_small_recv = 4'd4;
        exp_small_err  = 64'd2;
`endif
        RSTX      = 1'b0;
        ENABLE    = 1'b0;
        CLEAR     = 1'b0;
        WIN_LEN   = 32'd100;
        SNAP_REQ  = 1'b0;
        BIT_VALID = 1'b0;
        BIT_ERR   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_locked", {63'd0, locked}, 64'd0);
        check("rst_start",  {63'd0, meas_start}, 64'd0);
        check("rst_recv",   {6'd0, recv_cnt}, 64'd0);
        check("rst_err",    err_cnt, 64'd0);
        RSTX = 1'b1;
        tick();

        // Lock acquisition: 15 clean, 1 error, 16 clean
        ENABLE = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0);
        check("lock_31bits", {63'd0, locked}, 64'd0);
        send(1'b1, 1'b0);
        check("lock_32bits", {63'd0, locked}, 64'd1);

        // Window 1: 100 valid bits with errors at 10, 50, 90
        for (int i = 1; i <= 100; i++) begin
            send(1'b1, (i == 10) || (i == 50) || (i == 90));
            if (i == 99) check("win1_no_start_99", {63'd0, meas_start}, 64'd0);
        end
        check("win1_start", {63'd0, meas_start}, 64'd1);
        check("win1_recv",  {6'd0, recv_cnt}, 64'd100);
        check("win1_err",   err_cnt, 64'd3);
        check("win1_locked", {63'd0, locked}, 64'd1);

        // Window 2: first bit lands in the SNAP cycle
        for (int i = 1; i <= 100; i++) begin
            send(1'b1, 1'b0);
            if (i == 1) begin
                check("win2_start_low", {63'd0, meas_start}, 64'd0);
                check("win2_recv_held", {6'd0, recv_cnt}, 64'd100);
            end
        end
        check("win2_start", {63'd0, meas_start}, 64'd1);
        check("win2_recv",  {6'd0, recv_cnt}, 64'd200);
        check("win2_err",   err_cnt, 64'd3);

        // Unlock: 8 consecutive errored bits
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
        check("unlock_7err", {63'd0, locked}, 64'd1);
        send(1'b1, 1'b1);
        check("unlock_8err", {63'd0, locked}, 64'd0);

        // SNAP_REQ in ACQ is ignored and not queued
        SNAP_REQ = 1'b1;
        tick();
        SNAP_REQ = 1'b0;
        check("acq_snapreq", {63'd0, meas_start}, 64'd0);
        tick();
        check("acq_snapreq_noq", {63'd0, meas_start}, 64'd0);

        // Relock, then manual snapshot shows the 8 unlock errors were counted
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        check("relock", {63'd0, locked}, 64'd1);
        SNAP_REQ = 1'b1;
        tick();
        SNAP_REQ = 1'b0;
        check("man_start", {63'd0, meas_start}, 64'd1);
        check("man_recv",  {6'd0, recv_cnt}, 64'd208);
        check("man_err",   err_cnt, 64'd11);
        tick();
        check("man_start_1cyc", {63'd0, meas_start}, 64'd0);

        // CLEAR on the window-end bit drops the snapshot
        for (int i = 0; i < 99; i++) send(1'b1, 1'b0);
        CLEAR = 1'b1;
        send(1'b1, 1'b0);
        CLEAR = 1'b0;
        check("clr_start",  {63'd0, meas_start}, 64'd0);
        check("clr_recv",   {6'd0, recv_cnt}, 64'd0);
        check("clr_err",    err_cnt, 64'd0);
        check("clr_locked", {63'd0, locked}, 64'd1);

        // 20 bits, errors at 5 and 18; small instance saturates or wraps
        WIN_LEN = 32'd0;
        for (int i = 1; i <= 20; i++) send(1'b1, (i == 5) || (i == 18));
        check("nowin_no_start", {63'd0, meas_start}, 64'd0);
        SNAP_REQ = 1'b1;
        tick();
        SNAP_REQ = 1'b0;
        check("sat_start",       {63'd0, meas_start}, 64'd1);
        check("sat_recv_wide",   {6'd0, recv_cnt}, 64'd20);
        check("sat_err_wide",    err_cnt, 64'd2);
        check("sat_small_start", {63'd0, s_meas_start}, 64'd1);
        check("sat_small_lock",  {63'd0, s_locked}, 64'd1);
        check("sat_small_recv",  {60'd0, s_recv_cnt}, {60'd0, exp_small_recv});
        check("sat_small_err",   s_err_cnt, exp_small_err);

        // ENABLE=0 from SNAP: IDLE, no pulse, snapshots held
        ENABLE   = 1'b0;
        SNAP_REQ = 1'b1;
        send(1'b1, 1'b0);
        check("dis_locked", {63'd0, locked}, 64'd0);
        check("dis_start",  {63'd0, meas_start}, 64'd0);
        send(1'b1, 1'b0);
        SNAP_REQ = 1'b0;
        check("dis_start2", {63'd0, meas_start}, 64'd0);
        check("dis_recv",   {6'd0, recv_cnt}, 64'd20);

        // Reset mid-MEAS clears outputs asynchronously
        ENABLE = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        check("pre_rst_locked", {63'd0, locked}, 64'd1);
        RSTX = 1'b0;
        #1;
        check("arst_locked", {63'd0, locked}, 64'd0);
        check("arst_recv",   {6'd0, recv_cnt}, 64'd0);
        check("arst_err",    err_cnt, 64'd0);
        tick();
        RSTX = 1'b1;
        tick();
        check("post_rst_locked", {63'd0, locked}, 64'd0);
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0);
        check("post_rst_15", {63'd0, locked}, 64'd0);
        send(1'b1, 1'b0);
        check("post_rst_16", {63'd0, locked}, 64'd1);
        SNAP_REQ = 1'b1;
        tick();
        SNAP_REQ = 1'b0;
        check("post_rst_start", {63'd0, meas_start}, 64'd1);
        check("post_rst_recv",  {6'd0, recv_cnt}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
